// File: rtl/cp0_regfile.sv
// cp0_regfile: MIPS-style coprocessor-0 register file (BadVAddr, Count, Compare,
//   Status, Cause, EPC) with exception/ERET commit and interrupt status outputs.
// Ports: clk/rst (async active-high); hw_int level interrupts; wen/waddr/wdata
//   MTC0 write; raddr/rdata combinational MFC0 read; cp0_exp_* exception commit;
//   cp0_exl_clean ERET; epc_address, allow_interrupt, interrupt_flag status.
// Optional timer (Count/Compare/TI) is built only when CP0_TIMER_EN is defined.
module cp0_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  hw_int,
  input  logic        wen,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic        cp0_exp_en,
  input  logic [4:0]  cp0_exp_code,
  input  logic [31:0] cp0_exp_epc,
  input  logic        in_delay_slot,
  input  logic [31:0] cp0_exp_bad_vaddr,
  input  logic        cp0_exp_bad_vaddr_wen,
  input  logic        cp0_exl_clean,
  output logic [31:0] epc_address,
  output logic        allow_interrupt,
  output logic [7:0]  interrupt_flag
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  logic [31:0] badvaddr;
  logic [31:0] epc;
  logic [31:0] count;
  logic [31:0] compare;
  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;
  logic        cause_bd;
  logic        cause_ti;
  logic [5:0]  cause_hw_ip;
  logic [1:0]  cause_sw_ip;
  logic [4:0]  cause_exc;
  logic [31:0] status_val;
  logic [31:0] cause_val;

  // Exception and ERET commits take the cycle; any MTC0 alongside is dropped.
  logic mtc0;
  logic wr_status;
  logic wr_cause;
  logic wr_epc;

  assign mtc0      = wen & ~cp0_exp_en & ~cp0_exl_clean;
  assign wr_status = mtc0 && (waddr == REG_STATUS);
  assign wr_cause  = mtc0 && (waddr == REG_CAUSE);
  assign wr_epc    = mtc0 && (waddr == REG_EPC);

  // Status: only IM, EXL and IE are stored; BEV reads back as 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_im  <= 8'h00;
      status_exl <= 1'b0;
      status_ie  <= 1'b0;
    end else if (cp0_exp_en) begin
      status_exl <= 1'b1;
    end else if (cp0_exl_clean) begin
      status_exl <= 1'b0;
    end else if (wr_status) begin
      status_im  <= wdata[15:8];
      status_exl <= wdata[1];
      status_ie  <= wdata[0];
    end
  end

  // Cause: hardware IP lines resampled every edge; BD only captured for the
  // first exception (nested exceptions keep the original return context).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_bd    <= 1'b0;
      cause_hw_ip <= 6'd0;
      cause_sw_ip <= 2'd0;
      cause_exc   <= 5'd0;
    end else begin
      cause_hw_ip <= hw_int;
      if (cp0_exp_en) begin
        cause_exc <= cp0_exp_code;
        if (!status_exl) begin
          cause_bd <= in_delay_slot;
        end
      end
      if (wr_cause) begin
        cause_sw_ip <= wdata[9:8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc <= 32'd0;
    end else if (cp0_exp_en && !status_exl) begin
      epc <= cp0_exp_epc;
    end else if (wr_epc) begin
      epc <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      badvaddr <= 32'd0;
    end else if (cp0_exp_bad_vaddr_wen) begin
      badvaddr <= cp0_exp_bad_vaddr;
    end
  end

`ifdef CP0_TIMER_EN
  logic tick;
  logic wr_count;
  logic wr_compare;

  assign wr_count   = mtc0 && (waddr == REG_COUNT);
  assign wr_compare = mtc0 && (waddr == REG_COMPARE);

  // Count advances every other cycle; a software write wins over the
  // increment but the tick phase keeps running. A Compare write clears TI
  // even if the same edge would have matched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick     <= 1'b0;
      count    <= 32'd0;
      compare  <= 32'd0;
      cause_ti <= 1'b0;
    end else begin
      tick <= ~tick;
      if (wr_count) begin
        count <= wdata;
      end else if (tick) begin
        count <= count + 32'd1;
      end
      if (wr_compare) begin
        compare <= wdata;
      end
      if (wr_compare) begin
        cause_ti <= 1'b0;
      end else if (tick && !wr_count && ((count + 32'd1) == compare)) begin
        cause_ti <= 1'b1;
      end
    end
  end
`else
  assign count    = 32'd0;
  assign compare  = 32'd0;
  assign cause_ti = 1'b0;
`endif

  assign status_val = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
  // IP[15] is shared between hw_int[5] and the timer interrupt.
  assign cause_val  = {cause_bd, cause_ti, 14'd0, cause_hw_ip[5] | cause_ti,
                       cause_hw_ip[4:0], cause_sw_ip, 1'b0, cause_exc, 2'b00};

  always_comb begin
    rdata = 32'd0;
    case (raddr)
      REG_BADVADDR: rdata = badvaddr;
      REG_COUNT:    rdata = count;
      REG_COMPARE:  rdata = compare;
      REG_STATUS:   rdata = status_val;
      REG_CAUSE:    rdata = cause_val;
      REG_EPC:      rdata = epc;
      default:      rdata = 32'd0;
    endcase
  end

  assign epc_address     = epc;
  assign allow_interrupt = status_ie & ~status_exl;
  assign interrupt_flag  = status_im & cause_val[15:8];

endmodule
